temporal_select_arbiter: RTL and testbench

Gamma-cycle scheduler that shares one temporal `select` line, driving a downstream binary-to-temporal mux, among several temporal requesters. Free-runs the gamma-cycle phase counter. Each gamma cycle it grants the earliest-arriving request, with a configurable tie-break. It regenerates the winner's spike on `select` and reports the winner's index and arrival phase in binary at the next cycle boundary.

---
 rtl/temporal_select_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_temporal_select_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/temporal_select_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : temporal_select_arbiter
//  Purpose  : Gamma-cycle scheduler sharing one temporal `select` line among
//             NUM_REQ temporal requesters. A free-running phase counter
//             defines gamma cycles; the earliest-arriving request of each
//             cycle wins, its spike is regenerated on `select`, and the
//             winner's index and arrival phase are reported in binary at the
//             following cycle boundary.
//  Config   : `RR_PRIORITY_EN` -- when defined, ties go round-robin from a
//             priority pointer; otherwise the lowest index wins ties.
//  Ports    : aclk, grst_n (async, active-low), enable, req[NUM_REQ]
//             -> phase, gamma_start, grant, select, result_valid,
//                result_hit, result_id, result_time, busy
//  Revision : 1.0  initial release
// ============================================================================
module temporal_select_arbiter #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int NUM_REQ           = 4,
  localparam int PW = $clog2(GAMMA_CYCLE_WIDTH),
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               aclk,
  input  logic               grst_n,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [PW-1:0]      phase,
  output logic               gamma_start,
  output logic [NUM_REQ-1:0] grant,
  output logic               select,
  output logic               result_valid,
  output logic               result_hit,
  output logic [IW-1:0]      result_id,
  output logic [PW-1:0]      result_time,
  output logic               busy
);

  localparam logic [PW-1:0] c_last_phase = PW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [PW-1:0] c_pulse_load = PW'(PULSE_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [PW-1:0]      r_phase;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_captured;
  logic [IW-1:0]      r_cap_id;
  logic [PW-1:0]      r_cap_time;
  logic               r_pend;
  logic               r_select;
  logic [PW-1:0]      r_cnt;
  logic               r_res_valid;
  logic               r_res_hit;
  logic [IW-1:0]      r_res_id;
  logic [PW-1:0]      r_res_time;

  logic               w_run;
  logic               w_end;
  logic               w_cap;
  logic               w_win_found;
  logic [IW-1:0]      w_win_id;
  logic [IW-1:0]      w_idx;

`ifdef RR_PRIORITY_EN
  logic [IW-1:0]      r_ptr;
  logic [IW:0]        w_sum;
`endif

  assign w_run = (r_state == S_RUN);
  assign w_end = w_run && (r_phase == c_last_phase);
  assign w_cap = w_run && !r_captured && w_win_found;

  // Winner search: scan starting at the pointer (round-robin) or at 0.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_idx       = '0;
`ifdef RR_PRIORITY_EN
    w_sum       = '0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef RR_PRIORITY_EN
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      end
      w_idx = w_sum[IW-1:0];
`else
      w_idx = IW'(k);
`endif
      if (!w_win_found && req[w_idx]) begin
        w_win_found = 1'b1;
        w_win_id    = w_idx;
      end
    end
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if ((r_phase == c_last_phase) && !enable) w_state_nxt = S_LAST;
      S_LAST:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      r_phase     <= '0;
      r_grant     <= '0;
      r_captured  <= 1'b0;
      r_cap_id    <= '0;
      r_cap_time  <= '0;
      r_pend      <= 1'b0;
      r_select    <= 1'b0;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_hit   <= 1'b0;
      r_res_id    <= '0;
      r_res_time  <= '0;
`ifdef RR_PRIORITY_EN
      r_ptr       <= '0;
`endif
    end else begin
      r_res_valid <= 1'b0;
      r_phase     <= w_run ? r_phase + 1'b1 : '0;

      // Pulse regeneration: one cycle of arming after capture, then
      // PULSE_WIDTH cycles high.
      if (r_pend) begin
        r_select <= 1'b1;
        r_cnt    <= c_pulse_load;
        r_pend   <= 1'b0;
      end else if (r_select) begin
        if (r_cnt == '0) begin
          r_select <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end

      if (w_cap) begin
        r_captured <= 1'b1;
        r_cap_id   <= w_win_id;
        r_cap_time <= r_phase;
        r_grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_id;
        r_pend     <= 1'b1;
`ifdef RR_PRIORITY_EN
        r_ptr      <= (w_win_id == IW'(NUM_REQ - 1)) ? '0 : w_win_id + 1'b1;
`endif
      end

      // Cycle boundary: report (including a capture made in this very last
      // phase), then clear per-cycle state. This overrides the updates
      // above so nothing spills into the next gamma cycle.
      if (w_end) begin
        r_res_valid <= 1'b1;
        r_res_hit   <= r_captured | w_cap;
        r_res_id    <= w_cap ? w_win_id : r_cap_id;
        r_res_time  <= w_cap ? r_phase  : r_cap_time;
        r_captured  <= 1'b0;
        r_cap_id    <= '0;
        r_cap_time  <= '0;
        r_grant     <= '0;
        r_pend      <= 1'b0;
        r_select    <= 1'b0;
      end
    end
  end

  assign phase        = r_phase;
  assign gamma_start  = w_run && (r_phase == '0);
  assign grant        = r_grant;
  assign select       = r_select;
  assign result_valid = r_res_valid;
  assign result_hit   = r_res_hit;
  assign result_id    = r_res_id;
  assign result_time  = r_res_time;
  assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_temporal_select_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_temporal_select_arbiter
//  Purpose  : Self-checking bench for temporal_select_arbiter. A per-cycle
//             behavioural model tracks mode, phase and the captured winner;
//             expected outputs are derived arithmetically from that record.
//  Revision : 1.0  initial release
// ============================================================================
module tb_temporal_select_arbiter;

  localparam int G  = 16;
  localparam int PL = 8;
  localparam int N  = 4;
  localparam int PW = $clog2(G);
  localparam int IW = $clog2(N);

  logic          aclk = 1'b0;
  logic          grst_n;
  logic          enable;
  logic [N-1:0]  req;
  logic [PW-1:0] phase;
  logic          gamma_start;
  logic [N-1:0]  grant;
  logic          select;
  logic          result_valid;
  logic          result_hit;
  logic [IW-1:0] result_id;
  logic [PW-1:0] result_time;
  logic          busy;

  temporal_select_arbiter #(
    .GAMMA_CYCLE_WIDTH(G),
    .PULSE_WIDTH(PL),
    .NUM_REQ(N)
  ) dut (
    .aclk(aclk), .grst_n(grst_n), .enable(enable), .req(req),
    .phase(phase), .gamma_start(gamma_start), .grant(grant),
    .select(select), .result_valid(result_valid), .result_hit(result_hit),
    .result_id(result_id), .result_time(result_time), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  // Model state (0 idle, 1 run, 2 last)
  int m_mode, m_phase, m_cap, m_cap_phase, m_cap_id, m_ptr;
  int m_rv, m_rhit, m_rid, m_rtime;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_cap = 0; m_cap_phase = 0; m_cap_id = 0;
    m_ptr = 0; m_rv = 0; m_rhit = 0; m_rid = 0; m_rtime = 0;
  endtask

  task automatic check_all();
    int ph, gnt, sel;
    bit run;
    run = (m_mode == 1);
    ph  = run ? m_phase : 0;
    gnt = (run && m_cap != 0 && m_phase > m_cap_phase) ? (1 << m_cap_id) : 0;
    sel = (run && m_cap != 0 && m_phase >= m_cap_phase + 2 &&
           m_phase <= m_cap_phase + 1 + PL) ? 1 : 0;
    chk_eq("phase", 32'(phase), 32'(ph));
    chk_eq("gamma_start", 32'(gamma_start), 32'(run && ph == 0));
    chk_eq("busy", 32'(busy), 32'(m_mode != 0));
    chk_eq("grant", 32'(grant), 32'(gnt));
    chk_eq("select", 32'(select), 32'(sel));
    chk_eq("result_valid", 32'(result_valid), 32'(m_rv));
    chk_eq("result_hit", 32'(result_hit), 32'(m_rhit));
    chk_eq("result_id", 32'(result_id), 32'(m_rid));
    chk_eq("result_time", 32'(result_time), 32'(m_rtime));
  endtask

  task automatic model_step(input logic en, input logic [N-1:0] rq);
    int start, idx;
    case (m_mode)
      0: begin
        m_rv = 0;
        if (en) begin m_mode = 1; m_phase = 0; m_cap = 0; end
      end
      1: begin
        m_rv = 0;
        if (m_cap == 0 && rq != 0) begin
`ifdef RR_PRIORITY_EN
          start = m_ptr;
`else
          start = 0;
`endif
          for (int k = 0; k < N; k++) begin
            idx = (start + k) % N;
            if (m_cap == 0 && rq[idx]) begin
              m_cap = 1; m_cap_id = idx; m_cap_phase = m_phase;
            end
          end
`ifdef RR_PRIORITY_EN
          m_ptr = (m_cap_id + 1) % N;
`endif
        end
        if (m_phase == G - 1) begin
          m_rv = 1;
          m_rhit  = m_cap;
          m_rid   = m_cap ? m_cap_id : 0;
          m_rtime = m_cap ? m_cap_phase : 0;
          m_cap = 0; m_phase = 0;
          m_mode = en ? 1 : 2;
        end else begin
          m_phase++;
        end
      end
      default: begin
        m_rv = 0; m_mode = 0; m_phase = 0;
      end
    endcase
  endtask

  // One clock: check current outputs, drive inputs, advance model.
  task automatic cyc(input logic en, input logic [N-1:0] rq);
    check_all();
    enable = en;
    req    = rq;
    model_step(en, rq);
    @(negedge aclk);
  endtask

  task automatic run_to(input int p, input logic en, input logic [N-1:0] rq);
    int guard = 0;
    while (!(m_mode == 1 && m_phase == p)) begin
      cyc(en, rq);
      guard++;
      if (guard > 200) begin
        chk_eq("run_to_timeout", 0, 1);
        break;
      end
    end
  endtask

  int exp_w[3];
  logic [N-1:0] rq_r;
  logic en_r;

  initial begin
`ifdef RR_PRIORITY_EN
    exp_w = '{1, 3, 1};
`else
    exp_w = '{1, 1, 1};
`endif
    grst_n = 1'b0; enable = 1'b0; req = '0;
    model_reset();
    @(negedge aclk);
    check_all();
    @(negedge aclk);
    check_all();
    grst_n = 1'b1;

    // Basic capture: req[2] at phase 3
    cyc(1'b1, '0);
    run_to(3, 1'b1, '0);
    cyc(1'b1, 4'b0100);
    chk_eq("grant_p4", 32'(grant), 32'd4);
    run_to(5, 1'b1, '0);
    chk_eq("sel_p5", 32'(select), 1);
    run_to(12, 1'b1, '0);
    chk_eq("sel_p12", 32'(select), 1);
    cyc(1'b1, '0);
    chk_eq("sel_p13", 32'(select), 0);
    run_to(0, 1'b1, '0);
    chk_eq("rep1_valid", 32'(result_valid), 1);
    chk_eq("rep1_hit", 32'(result_hit), 1);
    chk_eq("rep1_id", 32'(result_id), 2);
    chk_eq("rep1_time", 32'(result_time), 3);

    // Late captures: phase 13 gives a one-cycle pulse at 15
    run_to(13, 1'b1, '0);
    cyc(1'b1, 4'b0010);
    chk_eq("sel_p14", 32'(select), 0);
    run_to(15, 1'b1, '0);
    chk_eq("sel_p15", 32'(select), 1);
    run_to(0, 1'b1, '0);
    chk_eq("rep2_id", 32'(result_id), 1);
    chk_eq("rep2_time", 32'(result_time), 13);
    // capture at the final phase: no pulse, still reported
    run_to(15, 1'b1, '0);
    cyc(1'b1, 4'b0001);
    chk_eq("sel_after_last_cap", 32'(select), 0);
    chk_eq("grant_after_last_cap", 32'(grant), 0);
    chk_eq("rep3_hit", 32'(result_hit), 1);
    chk_eq("rep3_id", 32'(result_id), 0);
    chk_eq("rep3_time", 32'(result_time), 15);

    // Empty cycle
    cyc(1'b1, '0);
    run_to(0, 1'b1, '0);
    chk_eq("rep4_valid", 32'(result_valid), 1);
    chk_eq("rep4_hit", 32'(result_hit), 0);
    chk_eq("rep4_id", 32'(result_id), 0);
    chk_eq("rep4_time", 32'(result_time), 0);

    // Ties: 1010 held for three full cycles
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < G; k++) cyc(1'b1, 4'b1010);
      chk_eq($sformatf("tie_winner%0d", c), 32'(result_id), 32'(exp_w[c]));
      chk_eq($sformatf("tie_time%0d", c), 32'(result_time), 0);
    end

    // Enable drop mid-cycle
    run_to(7, 1'b1, '0);
    begin
      int guard = 0;
      while (m_mode != 2 && guard < 40) begin cyc(1'b0, '0); guard++; end
      if (m_mode != 2) chk_eq("last_timeout", 0, 1);
    end
    chk_eq("last_valid", 32'(result_valid), 1);
    chk_eq("last_busy", 32'(busy), 1);
    cyc(1'b0, '0);
    chk_eq("idle_busy", 32'(busy), 0);
    chk_eq("idle_phase", 32'(phase), 0);
    cyc(1'b0, 4'b1111);
    cyc(1'b0, '0);

    // Reset mid-RUN with select high
    cyc(1'b1, '0);
    run_to(2, 1'b1, '0);
    cyc(1'b1, 4'b1000);
    run_to(5, 1'b1, '0);
    chk_eq("pre_rst_sel", 32'(select), 1);
    grst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    enable = 1'b1; req = '0;
    @(negedge aclk);
    check_all();
    grst_n = 1'b1;
    cyc(1'b1, '0);
    chk_eq("post_rst_valid", 32'(result_valid), 0);
    chk_eq("post_rst_phase", 32'(phase), 0);

    // Randomized traffic
    rq_r = '0; en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rq_r = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) rq_r = '0;
      en_r = ($urandom_range(0, 99) < 96);
      cyc(en_r, rq_r);
    end
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
